ts4231_config_scheduler: RTL and testbench

Sequences a single ts4231Configurator engine across up to N TS4231 light-sensor front ends. It muxes the engine's envelope/data pins onto one sensor at a time, runs each configuration attempt with a timeout, and retries a bounded number of times. It reports per-sensor configured/failed status. It sits between the sensor I/O pads and the configurator engine, upstream of the pulse-decoding datapath.

---
 rtl/ts4231_config_scheduler.sv | 226 ++++++++++++++++++++++
 tb/tb_ts4231_config_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ts4231_config_scheduler.sv
// ---------------------------------------------------------------------------
// ts4231_config_scheduler
//
// Time-shares one TS4231 configurator engine across N_SENSORS light-sensor
// front ends. Each enabled sensor in turn is muxed onto the engine, given a
// settle window with the engine held in reset, and then one or more
// configuration attempts, each bounded by a timeout. The per-sensor result
// is reported in configured_mask / failed_mask.
//
// Ports
//   clk_96MHz, rst_n        : clock, synchronous active-low reset
//   start, sensor_enable    : scan request (taken only in IDLE) and channel set
//   e_in, d_in              : registered sensor pad inputs
//   e_out/e_oe, d_out/d_oe  : sensor pad drives (only the selected channel)
//   eng_e_in, eng_d_in      : selected sensor's pads towards the engine
//   eng_e_out/oe, eng_d_out/oe : engine pad drives
//   cfg_reconfigure         : engine reconfigure request (high in RUN)
//   cfg_configured          : engine configured status
//   configured_mask, failed_mask : per-sensor results
//   busy, done, sel_idx     : scan status
// ---------------------------------------------------------------------------
module ts4231_config_scheduler #(
   parameter int N_SENSORS      = 4,
   parameter int SETTLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 9_600_000,
   parameter int MAX_ATTEMPTS   = 3
) (
   input  logic                      clk_96MHz,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [N_SENSORS-1:0]      sensor_enable,
   input  logic [N_SENSORS-1:0]      e_in,
   input  logic [N_SENSORS-1:0]      d_in,
   output logic [N_SENSORS-1:0]      e_out,
   output logic [N_SENSORS-1:0]      e_oe,
   output logic [N_SENSORS-1:0]      d_out,
   output logic [N_SENSORS-1:0]      d_oe,
   output logic                      eng_e_in,
   output logic                      eng_d_in,
   input  logic                      eng_e_out,
   input  logic                      eng_e_oe,
   input  logic                      eng_d_out,
   input  logic                      eng_d_oe,
   output logic                      cfg_reconfigure,
   input  logic                      cfg_configured,
   output logic [N_SENSORS-1:0]      configured_mask,
   output logic [N_SENSORS-1:0]      failed_mask,
   output logic                      busy,
   output logic                      done,
   output logic [((N_SENSORS > 1) ? $clog2(N_SENSORS) : 1)-1:0] sel_idx
);

   localparam int IDX_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_RUN,
      ST_NEXT,
      ST_DONE
   } state_t;

   state_t               state_q, state_d;
   logic [N_SENSORS-1:0] en_q, en_d;
   logic [IDX_W-1:0]     sel_idx_q, sel_idx_d;
   logic [ATT_W-1:0]     attempt_q, attempt_d;
   logic [SET_W-1:0]     settle_cnt_q, settle_cnt_d;
   logic [TMO_W-1:0]     timeout_cnt_q, timeout_cnt_d;
   logic                 armed_q, armed_d;
   logic [N_SENSORS-1:0] configured_mask_q, configured_mask_d;
   logic [N_SENSORS-1:0] failed_mask_q, failed_mask_d;
   logic [IDX_W:0]       hit;

   // Lowest set bit of mask at or above index 'from'; MSB of result = found.
   function automatic logic [IDX_W:0] find_set_bit(input logic [N_SENSORS-1:0] mask,
                                                   input int from);
      logic [IDX_W:0] res;
      res = '0;
      for (int i = N_SENSORS - 1; i >= 0; i--) begin
         if (mask[i] && (i >= from)) begin
            res = {1'b1, IDX_W'(i)};
         end
      end
      return res;
   endfunction

   // Next-state logic for the scan sequencer.
   always_comb begin
      state_d           = state_q;
      en_d              = en_q;
      sel_idx_d         = sel_idx_q;
      attempt_d         = attempt_q;
      settle_cnt_d      = settle_cnt_q;
      timeout_cnt_d     = timeout_cnt_q;
      armed_d           = armed_q;
      configured_mask_d = configured_mask_q;
      failed_mask_d     = failed_mask_q;
      hit               = '0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               en_d              = sensor_enable;
               configured_mask_d = '0;
               failed_mask_d     = '0;
               attempt_d         = ATT_W'(1);
               settle_cnt_d      = '0;
               hit               = find_set_bit(sensor_enable, 0);
               if (hit[IDX_W]) begin
                  sel_idx_d = hit[IDX_W-1:0];
                  state_d   = ST_SELECT;
               end else begin
                  state_d   = ST_DONE;
               end
            end
         end

         ST_SELECT: begin
            if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
               timeout_cnt_d = '0;
               armed_d       = 1'b0;
               state_d       = ST_RUN;
            end else begin
               settle_cnt_d = settle_cnt_q + SET_W'(1);
            end
         end

         ST_RUN: begin
            // A configured level only counts after the engine has been seen
            // low in this attempt, so a stale high from the last sensor is ignored.
            armed_d = armed_q | ~cfg_configured;
            if (armed_q && cfg_configured) begin
               configured_mask_d[sel_idx_q] = 1'b1;
               state_d                      = ST_NEXT;
            end else if (timeout_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               if (attempt_q == ATT_W'(MAX_ATTEMPTS)) begin
                  failed_mask_d[sel_idx_q] = 1'b1;
                  state_d                  = ST_NEXT;
               end else begin
                  attempt_d    = attempt_q + ATT_W'(1);
                  settle_cnt_d = '0;
                  state_d      = ST_SELECT;
               end
            end else begin
               timeout_cnt_d = timeout_cnt_q + TMO_W'(1);
            end
         end

         ST_NEXT: begin
            // Only search above the current index; the scan never wraps.
            hit          = find_set_bit(en_q, int'(sel_idx_q) + 1);
            attempt_d    = ATT_W'(1);
            settle_cnt_d = '0;
            if (hit[IDX_W]) begin
               sel_idx_d = hit[IDX_W-1:0];
               state_d   = ST_SELECT;
            end else begin
               state_d   = ST_DONE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_96MHz) begin
      if (!rst_n) begin
         state_q           <= ST_IDLE;
         en_q              <= '0;
         sel_idx_q         <= '0;
         attempt_q         <= '0;
         settle_cnt_q      <= '0;
         timeout_cnt_q     <= '0;
         armed_q           <= 1'b0;
         configured_mask_q <= '0;
         failed_mask_q     <= '0;
      end else begin
         state_q           <= state_d;
         en_q              <= en_d;
         sel_idx_q         <= sel_idx_d;
         attempt_q         <= attempt_d;
         settle_cnt_q      <= settle_cnt_d;
         timeout_cnt_q     <= timeout_cnt_d;
         armed_q           <= armed_d;
         configured_mask_q <= configured_mask_d;
         failed_mask_q     <= failed_mask_d;
      end
   end

   // Pad mux: only the selected channel is connected, and only while the
   // engine is actually working on it; the engine otherwise sees an idle-high bus.
   always_comb begin
      e_out    = '0;
      e_oe     = '0;
      d_out    = '0;
      d_oe     = '0;
      eng_e_in = 1'b1;
      eng_d_in = 1'b1;
      if ((state_q == ST_SELECT) || (state_q == ST_RUN)) begin
         e_out[sel_idx_q] = eng_e_out;
         e_oe[sel_idx_q]  = eng_e_oe;
         d_out[sel_idx_q] = eng_d_out;
         d_oe[sel_idx_q]  = eng_d_oe;
         eng_e_in         = e_in[sel_idx_q];
         eng_d_in         = d_in[sel_idx_q];
      end
   end

   assign cfg_reconfigure = (state_q == ST_RUN);
   assign busy            = (state_q == ST_SELECT) || (state_q == ST_RUN) || (state_q == ST_NEXT);
   assign done            = (state_q == ST_DONE);
   assign sel_idx         = sel_idx_q;
   assign configured_mask = configured_mask_q;
   assign failed_mask     = failed_mask_q;

endmodule

// File: tb/tb_ts4231_config_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ts4231_config_scheduler
//
// Drives directed scans through the scheduler against a behavioural engine
// whose configured output follows a per-sensor low window. Expected RUN
// windows and scan results are queued as each scan is issued; a monitor pops
// them as the DUT produces RUN windows and done pulses.
// ---------------------------------------------------------------------------
module tb_ts4231_config_scheduler;

   localparam int N      = 4;
   localparam int SETTLE = 16;
   localparam int TMO    = 1000;
   localparam int MAXA   = 3;
   localparam int BUDGET = 20000;

   logic         clk_96MHz = 1'b0;
   logic         rst_n;
   logic         start;
   logic [N-1:0] sensor_enable;
   logic [N-1:0] e_in, d_in;
   logic [N-1:0] e_out, e_oe, d_out, d_oe;
   logic         eng_e_in, eng_d_in;
   logic         eng_e_out, eng_e_oe, eng_d_out, eng_d_oe;
   logic         cfg_reconfigure;
   logic         cfg_configured = 1'b0;
   logic [N-1:0] configured_mask, failed_mask;
   logic         busy, done;
   logic [1:0]   sel_idx;

   always #5 clk_96MHz = ~clk_96MHz;

   ts4231_config_scheduler #(
      .N_SENSORS     (N),
      .SETTLE_CYCLES (SETTLE),
      .TIMEOUT_CYCLES(TMO),
      .MAX_ATTEMPTS  (MAXA)
   ) dut (
      .clk_96MHz      (clk_96MHz),
      .rst_n          (rst_n),
      .start          (start),
      .sensor_enable  (sensor_enable),
      .e_in           (e_in),
      .d_in           (d_in),
      .e_out          (e_out),
      .e_oe           (e_oe),
      .d_out          (d_out),
      .d_oe           (d_oe),
      .eng_e_in       (eng_e_in),
      .eng_d_in       (eng_d_in),
      .eng_e_out      (eng_e_out),
      .eng_e_oe       (eng_e_oe),
      .eng_d_out      (eng_d_out),
      .eng_d_oe       (eng_d_oe),
      .cfg_reconfigure(cfg_reconfigure),
      .cfg_configured (cfg_configured),
      .configured_mask(configured_mask),
      .failed_mask    (failed_mask),
      .busy           (busy),
      .done           (done),
      .sel_idx        (sel_idx)
   );

   typedef struct {
      int sel;
      int settle;
      int len;
   } window_t;

   typedef struct {
      logic [N-1:0] cfg;
      logic [N-1:0] fail;
      logic [N-1:0] driven;
      int           busyCycles;
   } result_t;

   window_t winQ[$];
   result_t resQ[$];

   int lowStart[N];
   int lowEnd[N];
   int compared   = 0;
   int mismatched = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Behavioural engine: during RUN, configured is low inside the sensor's
   // [lowStart, lowEnd) window of RUN cycles and high otherwise; outside RUN
   // it keeps its last level, like a status flag left over from the last sensor.
   int rc = 0;
   always @(negedge clk_96MHz) begin
      if (cfg_reconfigure !== 1'b1) begin
         rc = 0;
      end else begin
         cfg_configured = !((rc >= lowStart[sel_idx]) && (rc < lowEnd[sel_idx]));
         rc++;
      end
   end

   // Monitor: measures SELECT settle length and RUN window length, checks the
   // mux at each RUN entry, and checks masks/driven channels/busy time at done.
   int           runLen    = 0;
   int           settleCnt = 0;
   int           busyCnt   = 0;
   int           curSel    = 0;
   logic         inRun     = 1'b0;
   logic [N-1:0] driven    = '0;
   logic [N-1:0] eIn       = 4'b0110;
   logic [N-1:0] dIn       = 4'b1010;

   always @(negedge clk_96MHz) begin
      if (rst_n !== 1'b1) begin
         if (inRun && (winQ.size() > 0)) void'(winQ.pop_front());
         inRun     = 1'b0;
         runLen    = 0;
         settleCnt = 0;
         busyCnt   = 0;
         driven    = '0;
      end else begin
         driven = driven | e_oe | d_oe | e_out | d_out;
         if (busy) busyCnt++;
         if (busy && !cfg_reconfigure && (|e_oe)) settleCnt++;
         if (cfg_reconfigure) begin
            if (!inRun) begin
               inRun  = 1'b1;
               runLen = 0;
               curSel = int'(sel_idx);
               if (winQ.size() == 0) begin
                  compared++;
                  mismatched++;
                  $display("[TB] FAIL unexpected_run: got sel %0d, expected no RUN window", curSel);
               end else begin
                  checkOutput("settle_len", settleCnt, winQ[0].settle);
                  checkOutput("mux_e_oe", e_oe, 1 << winQ[0].sel);
                  checkOutput("mux_d_out", d_out, 1 << winQ[0].sel);
                  checkOutput("eng_e_in", eng_e_in, eIn[winQ[0].sel]);
                  checkOutput("eng_d_in", eng_d_in, dIn[winQ[0].sel]);
               end
               settleCnt = 0;
            end
            runLen++;
         end else if (inRun) begin
            inRun = 1'b0;
            if (winQ.size() > 0) begin
               window_t w;
               w = winQ.pop_front();
               checkOutput("run_sel", curSel, w.sel);
               checkOutput("run_len", runLen, w.len);
            end
         end
         if (done) begin
            if (resQ.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_done: got done, expected none");
            end else begin
               result_t r;
               r = resQ.pop_front();
               checkOutput("configured_mask", configured_mask, r.cfg);
               checkOutput("failed_mask", failed_mask, r.fail);
               checkOutput("driven_channels", driven, r.driven);
               checkOutput("busy_cycles", busyCnt, r.busyCycles);
            end
            driven  = '0;
            busyCnt = 0;
         end
      end
   end

   task automatic pushWindows(input int sel, input int count, input int len);
      for (int i = 0; i < count; i++) begin
         winQ.push_back('{sel: sel, settle: SETTLE, len: len});
      end
   endtask

   task automatic pushResult(input logic [N-1:0] cfg, input logic [N-1:0] fail,
                             input logic [N-1:0] drv, input int busyCycles);
      resQ.push_back('{cfg: cfg, fail: fail, driven: drv, busyCycles: busyCycles});
   endtask

   // Issues one scan and waits (bounded) for done; optional stray start pulses.
   task automatic applyStimulus(input logic [N-1:0] en, input bit glitch, output int latency);
      int cyc;
      @(negedge clk_96MHz);
      sensor_enable = en;
      start         = 1'b1;
      @(negedge clk_96MHz);
      start         = 1'b0;
      sensor_enable = 4'b1111;
      cyc           = 0;
      while (!done && (cyc < BUDGET)) begin
         @(negedge clk_96MHz);
         cyc++;
         start = glitch && ((cyc == 100) || (cyc == 400));
      end
      start   = 1'b0;
      latency = cyc;
      if (cyc >= BUDGET) begin
         compared++;
         mismatched++;
         $display("[TB] FAIL scan_timeout: got no done after %0d cycles, expected done", cyc);
      end
      @(negedge clk_96MHz);
   endtask

   initial begin
      int lat;
      int cyc;
      rst_n         = 1'b0;
      start         = 1'b0;
      sensor_enable = '0;
      e_in          = eIn;
      d_in          = dIn;
      eng_e_out     = 1'b1;
      eng_e_oe      = 1'b1;
      eng_d_out     = 1'b1;
      eng_d_oe      = 1'b1;
      for (int i = 0; i < N; i++) begin
         lowStart[i] = 0;
         lowEnd[i]   = 200;
      end

      repeat (3) @(posedge clk_96MHz);
      @(negedge clk_96MHz);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_reconf", cfg_reconfigure, 0);
      checkOutput("rst_e_oe", e_oe, 0);
      checkOutput("rst_d_oe", d_oe, 0);
      checkOutput("rst_cfg_mask", configured_mask, 0);
      checkOutput("rst_fail_mask", failed_mask, 0);
      checkOutput("rst_eng_e_in", eng_e_in, 1);
      checkOutput("rst_sel_idx", sel_idx, 0);
      checkOutput("rst_done", done, 0);
      rst_n = 1'b1;

      // Scan A: sensors 0,1,3 each configure after 200 low cycles, stray starts ignored.
      $display("[TB] scan A: enable 1011");
      pushWindows(0, 1, 201);
      pushWindows(1, 1, 201);
      pushWindows(3, 1, 201);
      pushResult(4'b1011, 4'b0000, 4'b1011, 3 * (SETTLE + 201 + 1));
      applyStimulus(4'b1011, 1'b1, lat);

      // Scan B: 0 stuck high (stale), 1 never, 2 high-low-high, 3 success on timeout cycle.
      $display("[TB] scan B: enable 1111 with retries");
      lowStart[0] = 0;  lowEnd[0] = 0;
      lowStart[1] = 0;  lowEnd[1] = 1 << 30;
      lowStart[2] = 50; lowEnd[2] = 60;
      lowStart[3] = 0;  lowEnd[3] = TMO - 1;
      pushWindows(0, MAXA, TMO);
      pushWindows(1, MAXA, TMO);
      pushWindows(2, 1, 61);
      pushWindows(3, 1, TMO);
      pushResult(4'b1100, 4'b0011, 4'b1111,
                 2 * (MAXA * (SETTLE + TMO) + 1) + (SETTLE + 61 + 1) + (SETTLE + TMO + 1));
      applyStimulus(4'b1111, 1'b0, lat);

      // Scan C: empty enable set goes straight to done.
      $display("[TB] scan C: enable 0000");
      pushResult(4'b0000, 4'b0000, 4'b0000, 0);
      applyStimulus(4'b0000, 1'b0, lat);
      checkOutput("empty_done_latency", lat, 0);

      // Reset in the middle of sensor 2's RUN window.
      $display("[TB] reset during RUN");
      lowStart[2] = 0;
      lowEnd[2]   = 900;
      winQ.push_back('{sel: 2, settle: SETTLE, len: 0});
      @(negedge clk_96MHz);
      sensor_enable = 4'b0100;
      start         = 1'b1;
      @(negedge clk_96MHz);
      start = 1'b0;
      cyc   = 0;
      while ((cfg_reconfigure !== 1'b1) && (cyc < 100)) begin
         @(negedge clk_96MHz);
         cyc++;
      end
      repeat (50) @(negedge clk_96MHz);
      checkOutput("pre_rst_sel", sel_idx, 2);
      checkOutput("pre_rst_reconf", cfg_reconfigure, 1);
      rst_n = 1'b0;
      @(posedge clk_96MHz);
      #1;
      checkOutput("mid_rst_busy", busy, 0);
      checkOutput("mid_rst_reconf", cfg_reconfigure, 0);
      checkOutput("mid_rst_e_oe", e_oe, 0);
      checkOutput("mid_rst_d_oe", d_oe, 0);
      checkOutput("mid_rst_e_out", e_out, 0);
      checkOutput("mid_rst_masks", {configured_mask, failed_mask}, 0);
      checkOutput("mid_rst_eng_in", {eng_e_in, eng_d_in}, 2'b11);
      checkOutput("mid_rst_sel", sel_idx, 0);
      repeat (3) @(negedge clk_96MHz);
      rst_n = 1'b1;
      repeat (5) @(negedge clk_96MHz);
      checkOutput("post_rst_busy", busy, 0);

      checkOutput("windows_left", winQ.size(), 0);
      checkOutput("results_left", resQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
